// File: rtl/tennis_pkg.sv
// Shared constants and types for the tennis match controller.
// State/winner codes are fixed so display logic can decode them directly.
package tennis_pkg;

  typedef logic [3:0] pos_t;
  typedef logic [3:0] score_t;

  localparam logic [1:0] ST_SERVE = 2'd0;
  localparam logic [1:0] ST_RALLY = 2'd1;
  localparam logic [1:0] ST_POINT = 2'd2;
  localparam logic [1:0] ST_OVER  = 2'd3;

  localparam logic [1:0] WIN_NONE  = 2'b00;
  localparam logic [1:0] WIN_RIGHT = 2'b01;
  localparam logic [1:0] WIN_LEFT  = 2'b10;

  localparam pos_t POS_RIGHT = 4'd0;
  localparam pos_t POS_LEFT  = 4'd15;

  typedef enum logic {
    SIDE_RIGHT = 1'b0,
    SIDE_LEFT  = 1'b1
  } side_e;

  function automatic pos_t edge_pos(side_e s);
    return (s == SIDE_LEFT) ? POS_LEFT : POS_RIGHT;
  endfunction

  function automatic side_e opponent(side_e s);
    return (s == SIDE_LEFT) ? SIDE_RIGHT : SIDE_LEFT;
  endfunction

endpackage

// File: rtl/tennis_match_ctrl_if.sv
// Paddle inputs, ball position and controller command/score outputs.
// master = match controller, slave = datapath/display side.
interface tennis_match_ctrl_if;
  import tennis_pkg::*;

  logic       left_btn;
  logic       right_btn;
  pos_t       ball_pos;
  logic       serve_right;
  logic       serve_left;
  logic       step_en;
  logic       hit;
  score_t     score_left;
  score_t     score_right;
  logic [1:0] state;
  logic [1:0] winner;

  modport master (
    input  left_btn, right_btn, ball_pos,
    output serve_right, serve_left, step_en, hit,
           score_left, score_right, state, winner
  );

  modport slave (
    output left_btn, right_btn, ball_pos,
    input  serve_right, serve_left, step_en, hit,
           score_left, score_right, state, winner
  );

endinterface

// File: rtl/tennis_match_ctrl_step_tick_gen.sv
// Ball step timebase: counts 0..DIV-1 while enabled and flags the wrap cycle.
module step_tick_gen #(
  parameter int unsigned DIV = 25_000_000
) (
  input  logic clk,
  input  logic reset,
  input  logic en,
  input  logic clr,
  output logic tick
);

  localparam int unsigned W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [W-1:0] LAST = W'(DIV - 1);

  logic [W-1:0] cnt_q, cnt_d;

  // tick ignores clr so the caller may derive clr from tick without a loop
  always_comb begin
    tick  = en && (cnt_q == LAST);
    cnt_d = cnt_q;
    if (clr)       cnt_d = '0;
    else if (tick) cnt_d = '0;
    else if (en)   cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

endmodule

// File: rtl/tennis_match_ctrl.sv
// Tennis match sequencer: serves, judges hits/misses/early swings,
// keeps score and declares the winner. All command pulses are registered.
module tennis_match_ctrl
  import tennis_pkg::*;
#(
  parameter int unsigned STEP_DIV   = 25_000_000,
  parameter int unsigned WIN_SCORE  = 7,
  parameter int unsigned POINT_HOLD = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  tennis_match_ctrl_if.master  bus
);

  localparam int unsigned HW = (POINT_HOLD > 1) ? $clog2(POINT_HOLD) : 1;
  localparam logic [HW-1:0] HOLD_LAST = HW'(POINT_HOLD - 1);
  localparam score_t WIN = score_t'(WIN_SCORE);

  logic [1:0]    state_q, state_d;
  side_e         server_q, server_d;
  logic          dir_up_q, dir_up_d;
  score_t        score_left_q, score_left_d;
  score_t        score_right_q, score_right_d;
  logic [1:0]    winner_q, winner_d;
  logic [HW-1:0] hold_q, hold_d;
  logic          serve_right_q, serve_right_d;
  logic          serve_left_q, serve_left_d;
  logic          step_en_q, step_en_d;
  logic          hit_q, hit_d;

  logic   tick;
  logic   tick_en;
  logic   tick_clr;
  logic   enter_point;
  side_e  receiver;
  side_e  point_to;
  logic   rx_btn;
  logic   at_edge;
  logic   srv_btn;
  score_t scorer_score;

  step_tick_gen #(.DIV(STEP_DIV)) u_step_tick (
    .clk   (clk),
    .reset (reset),
    .en    (tick_en),
    .clr   (tick_clr),
    .tick  (tick)
  );

  assign tick_en  = (state_q == ST_RALLY) || (state_q == ST_POINT);
  assign tick_clr = serve_right_q || serve_left_q || enter_point;

  assign receiver     = dir_up_q ? SIDE_LEFT : SIDE_RIGHT;
  assign rx_btn       = (receiver == SIDE_LEFT) ? bus.left_btn : bus.right_btn;
  assign at_edge      = (bus.ball_pos == edge_pos(receiver));
  assign srv_btn      = (server_q == SIDE_LEFT) ? bus.left_btn : bus.right_btn;
  assign scorer_score = (server_q == SIDE_LEFT) ? score_left_q : score_right_q;

  always_comb begin
    state_d       = state_q;
    server_d      = server_q;
    dir_up_d      = dir_up_q;
    score_left_d  = score_left_q;
    score_right_d = score_right_q;
    winner_d      = winner_q;
    hold_d        = hold_q;
    serve_right_d = 1'b0;
    serve_left_d  = 1'b0;
    step_en_d     = 1'b0;
    hit_d         = 1'b0;
    enter_point   = 1'b0;
    point_to      = opponent(receiver);

    case (state_q)
      ST_SERVE: begin
        if (srv_btn) begin
          serve_right_d = (server_q == SIDE_RIGHT);
          serve_left_d  = (server_q == SIDE_LEFT);
          dir_up_d      = (server_q == SIDE_RIGHT);
          state_d       = ST_RALLY;
        end
      end
      ST_RALLY: begin
        // receiver's press is judged first; it pre-empts a coincident step or miss
        if (rx_btn) begin
          if (at_edge) begin
            hit_d    = 1'b1;
            dir_up_d = ~dir_up_q;
          end else begin
            enter_point = 1'b1;
          end
        end else if (tick) begin
          if (at_edge) enter_point = 1'b1;
          else         step_en_d   = 1'b1;
        end
        if (enter_point) begin
          state_d  = ST_POINT;
          server_d = point_to;
          hold_d   = '0;
          if (point_to == SIDE_LEFT) score_left_d  = score_left_q + 4'd1;
          else                       score_right_d = score_right_q + 4'd1;
        end
      end
      ST_POINT: begin
        if (tick) begin
          if (hold_q == HOLD_LAST) begin
            if (scorer_score == WIN) begin
              state_d  = ST_OVER;
              winner_d = (server_q == SIDE_LEFT) ? WIN_LEFT : WIN_RIGHT;
            end else begin
              state_d = ST_SERVE;
            end
          end else begin
            hold_d = hold_q + 1'b1;
          end
        end
      end
      default: begin
        if (bus.left_btn && bus.right_btn) begin
          score_left_d  = '0;
          score_right_d = '0;
          winner_d      = WIN_NONE;
          server_d      = SIDE_RIGHT;
          dir_up_d      = 1'b1;
          state_d       = ST_SERVE;
        end
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= ST_SERVE;
      server_q      <= SIDE_RIGHT;
      dir_up_q      <= 1'b1;
      score_left_q  <= '0;
      score_right_q <= '0;
      winner_q      <= WIN_NONE;
      hold_q        <= '0;
      serve_right_q <= 1'b0;
      serve_left_q  <= 1'b0;
      step_en_q     <= 1'b0;
      hit_q         <= 1'b0;
    end else begin
      state_q       <= state_d;
      server_q      <= server_d;
      dir_up_q      <= dir_up_d;
      score_left_q  <= score_left_d;
      score_right_q <= score_right_d;
      winner_q      <= winner_d;
      hold_q        <= hold_d;
      serve_right_q <= serve_right_d;
      serve_left_q  <= serve_left_d;
      step_en_q     <= step_en_d;
      hit_q         <= hit_d;
    end
  end

  assign bus.serve_right = serve_right_q;
  assign bus.serve_left  = serve_left_q;
  assign bus.step_en     = step_en_q;
  assign bus.hit         = hit_q;
  assign bus.score_left  = score_left_q;
  assign bus.score_right = score_right_q;
  assign bus.state       = state_q;
  assign bus.winner      = winner_q;

endmodule
